// File: rtl/vote_input_conditioner_if.sv
// Button-in / vote-out bundle for vote_input_conditioner.
// The slave modport is the conditioner's view; master is the driver/observer side.
interface vote_input_conditioner_if;
    logic [3:0] button_i;
    logic [3:0] vote_pulse_o;
    logic       vote_valid_o;
    logic       reject_pulse_o;
    logic [7:0] reject_count_o;
    logic [3:0] btn_level_o;
    logic       busy_o;

    modport slave (
        input  button_i,
        output vote_pulse_o,
        output vote_valid_o,
        output reject_pulse_o,
        output reject_count_o,
        output btn_level_o,
        output busy_o
    );

    modport master (
        output button_i,
        input  vote_pulse_o,
        input  vote_valid_o,
        input  reject_pulse_o,
        input  reject_count_o,
        input  btn_level_o,
        input  busy_o
    );
endinterface

// File: rtl/vote_input_conditioner.sv
// Synchronise + debounce four candidate buttons and emit one one-hot vote per press.
// Define VOTE_LOCKOUT_EN to add a dead-time LOCKOUT state after every full release.
module vote_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    vote_input_conditioner_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0] level_w;
    logic [3:0] rise_w;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic                   level_q;
            logic                   mismatch;
            logic                   expire;

            assign mismatch = sync_q[SYNC_STAGES-1] ^ level_q;
            // The DEBOUNCE_CYCLES-th consecutive mismatch flips the level on this edge.
            assign expire   = mismatch && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q  <= '0;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], bus.button_i[gi]};
                    if (!mismatch) begin
                        cnt_q <= '0;
                    end else if (expire) begin
                        cnt_q   <= '0;
                        level_q <= ~level_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign level_w[gi] = level_q;
            assign rise_w[gi]  = expire & ~level_q;
        end
    endgenerate

`ifdef VOTE_LOCKOUT_EN
    typedef enum logic [1:0] {IDLE, HOLD, LOCKOUT} state_t;
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    logic [LK_W-1:0] lock_cnt_q;
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif

    state_t     state_q;
    logic [3:0] pe_q;
    logic [3:0] vote_pulse_q;
    logic       vote_valid_q;
    logic       reject_pulse_q;
    logic [7:0] reject_count_q;
    logic [7:0] reject_count_d;
    logic       busy_q;
    logic       pe_any;
    logic       accept;

    assign pe_any         = |pe_q;
    // Exactly one new press, and no other button already down.
    assign accept         = ((pe_q & (pe_q - 4'd1)) == 4'd0) && ((level_w & ~pe_q) == 4'd0);
    assign reject_count_d = (reject_count_q == 8'hFF) ? reject_count_q : reject_count_q + 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pe_q <= '0;
        end else begin
            pe_q <= rise_w;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            vote_pulse_q   <= '0;
            vote_valid_q   <= 1'b0;
            reject_pulse_q <= 1'b0;
            reject_count_q <= '0;
            busy_q         <= 1'b0;
`ifdef VOTE_LOCKOUT_EN
            lock_cnt_q     <= '0;
`endif
        end else begin
            vote_pulse_q   <= '0;
            vote_valid_q   <= 1'b0;
            reject_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pe_any) begin
                        if (accept) begin
                            vote_pulse_q <= pe_q;
                            vote_valid_q <= 1'b1;
                        end else begin
                            reject_pulse_q <= 1'b1;
                            reject_count_q <= reject_count_d;
                        end
                        state_q <= HOLD;
                        busy_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pe_any) begin
                        reject_pulse_q <= 1'b1;
                        reject_count_q <= reject_count_d;
                    end
                    if (level_w == 4'd0) begin
`ifdef VOTE_LOCKOUT_EN
                        state_q    <= LOCKOUT;
                        lock_cnt_q <= LK_W'(LOCKOUT_CYCLES - 1);
`else
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
`endif
                    end
                end
`ifdef VOTE_LOCKOUT_EN
                LOCKOUT: begin
                    if (pe_any) begin
                        reject_pulse_q <= 1'b1;
                        reject_count_q <= reject_count_d;
                    end
                    if (lock_cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vote_pulse_o   = vote_pulse_q;
    assign bus.vote_valid_o   = vote_valid_q;
    assign bus.reject_pulse_o = reject_pulse_q;
    assign bus.reject_count_o = reject_count_q;
    assign bus.btn_level_o    = level_w;
    assign bus.busy_o         = busy_q;

endmodule

// File: doc/vote_input_conditioner.md
# vote_input_conditioner

Front-end stage for the four candidate buttons of the voting machine. It synchronises and debounces the raw button inputs and enforces one-vote-per-press. It drives the vote tally logic with at most one single-cycle, one-hot vote pulse per physical press. Simultaneous or overlapping presses are rejected and counted rather than forwarded.

## Interface
- DEBOUNCE_CYCLES, 10: consecutive cycles a synchronised level must differ from the debounced level before the debounced level flips; legal ≥ 2.
- SYNC_STAGES, 2: synchroniser flops per button; legal ≥ 2.
- LOCKOUT_CYCLES, 8: dead time after all buttons released (only with VOTE_LOCKOUT_EN); legal ≥ 1.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately; release is synchronous to clock.
- button  in  4  raw, asynchronous candidate buttons, bit i = candidate i+1, active-high.
- vote_pulse  out  4  one-hot single-cycle accepted vote; reset 0.
- vote_valid  out  1  OR of vote_pulse, registered alongside it; reset 0.
- reject_pulse  out  1  single-cycle flag for a rejected press; reset 0.
- reject_count  out  8  saturating count of rejects (saturates at 255); reset 0.
- btn_level  out  4  debounced button levels; reset 0.
- busy  out  1  high whenever the FSM is not in IDLE; reset 0.

## Operation
- Per button: SYNC_STAGES-flop synchroniser feeds a debouncer.
  - Debouncer counter width is $clog2(DEBOUNCE_CYCLES+1).
  - On each edge where the sync output differs from btn_level, the counter increments. On any edge where they match, the counter clears.
  - When a mismatch is seen on the DEBOUNCE_CYCLES-th consecutive edge, btn_level[i] flips on that edge and the counter clears.
- A press event is a registered 0→1 flip of btn_level[i]; the press-event vector is pe[3:0].
- FSM states: IDLE, HOLD, LOCKOUT. LOCKOUT exists only with VOTE_LOCKOUT_EN.
- IDLE:
  - If pe has exactly one bit set and every other btn_level bit is 0: vote_pulse=pe and vote_valid=1 for one cycle, then go to HOLD.
  - If pe has ≥2 bits set, or one bit set while another btn_level bit is already 1: reject_pulse=1 for one cycle, reject_count increments, then go to HOLD.
  - Otherwise stay in IDLE.
- HOLD: no votes are emitted.
  - Any new press event in HOLD asserts reject_pulse and increments reject_count.
  - When btn_level==0: go to LOCKOUT (macro defined) or IDLE (macro undefined).
- LOCKOUT: a down-counter loads LOCKOUT_CYCLES-1 on entry and decrements each cycle; at 0, go to IDLE.
  - A press event during LOCKOUT is rejected (reject_pulse, count increment).
  - The FSM stays in LOCKOUT for the full count.
- Outputs at most one vote per physical press; holding a button never repeats a vote.
- reject_count holds at 255; further rejects still pulse reject_pulse.

## Timing
- Button rising, stable from before edge 0 (the first sampling edge), in IDLE:
  - btn_level rises after edge SYNC_STAGES+DEBOUNCE_CYCLES−1.
  - vote_pulse is high for exactly the one cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 12 with defaults).
- Release latency to btn_level==0 is the same SYNC_STAGES+DEBOUNCE_CYCLES−1. The FSM leaves HOLD on the following edge.
- Glitches shorter than DEBOUNCE_CYCLES cycles at the sync output never change btn_level.
- vote_pulse, vote_valid, reject_pulse and busy are all registered; there is no combinational path from button.
- Reset mid-debounce or mid-HOLD: all outputs go to 0 immediately and the FSM is in IDLE.
  - A button still held after reset release registers as a fresh press after the full latency.

## Configuration
- VOTE_LOCKOUT_EN defined: LOCKOUT state and its counter are built. After full release, busy stays high for LOCKOUT_CYCLES more cycles, and any press event in that window is rejected.
- VOTE_LOCKOUT_EN undefined: no LOCKOUT state or counter; HOLD→IDLE directly, and LOCKOUT_CYCLES is ignored.

## Test plan
- button[2] held 30 cycles, defaults → vote_pulse=4'b0100 for 1 cycle at edge 12, vote_valid=1 in the same cycle, no further pulses; busy returns to 0 after release (+8 cycles with macro).
- button[0] pulses of 5 cycles high and 5 cycles low, repeated → btn_level stays 0, no vote_pulse, no reject.
- button[1] and button[3] rise on the same cycle → reject_pulse once at edge 12, reject_count=1, vote_pulse stays 0.
- button[0] held, button[1] pressed 20 cycles later → one vote_pulse=4'b0001, then one reject_pulse, reject_count=1.
- 260 simultaneous two-button presses → reject_count saturates at 255; every attempt still produces reject_pulse.
- reset asserted 5 cycles after button[3] rises and released with button still held → outputs 0 during reset; vote_pulse=4'b1000 exactly 12 edges after reset release.
